sram_vga_arbiter: RTL and testbench

Owns the single SRAM port (via sram_conn) and shares it between two requesters. One is the framebuffer copy stream from sh_mem (writes). The other is the vga_machine pixel fetch (reads). Copy writes are buffered in a small FIFO and drained only inside the copy window when no display read is pending. Display reads always win. The block also enforces read-to-write bus turnaround and signals when a full copy has landed in SRAM.

---
 rtl/sram_vga_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_vga_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_vga_arbiter.sv
// sram_vga_arbiter: shares the single SRAM port between the framebuffer copy
// stream (buffered writes) and the VGA pixel fetch (reads, always win).
// Ports: cp_* copy write stream (valid/ready), copy_window gates writes,
//   copy_end pulses when the last-marked word is written; dp_* display reads
//   with RD_LAT-cycle return; sram_* registered SRAM command/data; fifo_level
//   reports copy buffer occupancy.
module sram_vga_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cp_valid,
  input  logic [ADDR_W-1:0]             cp_addr,
  input  logic [DATA_W-1:0]             cp_data,
  input  logic                          cp_last,
  output logic                          cp_ready,
  input  logic                          copy_window,
  output logic                          copy_end,
  input  logic                          dp_req,
  input  logic [ADDR_W-1:0]             dp_addr,
  output logic                          dp_valid,
  output logic [DATA_W-1:0]             dp_data,
  output logic                          sram_write,
  output logic                          sram_read,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wr_data,
  input  logic [DATA_W-1:0]             sram_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t state, state_nxt;

  // Copy write buffer
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;

  logic push, pop, eligible;

  // Read return tracking: bit i set means a read issued i+1 cycles ago
  logic [RD_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0] dp_hold;

  assign cp_ready   = (level != LVL_W'(FIFO_DEPTH));
  assign push       = cp_valid & cp_ready;
  assign fifo_level = level;

  // Buffered words only drain inside the copy window
  assign eligible = (level != '0) && copy_window;

  always_comb begin
    state_nxt = IDLE;
    pop       = 1'b0;
    if (dp_req) begin
      state_nxt = READ;
    end else if (eligible && state != READ) begin
      state_nxt = WRITE;
      pop       = 1'b1;
    end else if (eligible) begin
      // Coming out of a read: one dead cycle before driving write data
      state_nxt = TURN;
    end
  end

  // Storage needs no reset; only pointers and level define contents
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cp_addr;
      fifo_data[wr_ptr] <= cp_data;
      fifo_last[wr_ptr] <= cp_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sram_read    <= 1'b0;
      sram_write   <= 1'b0;
      sram_addr    <= '0;
      sram_wr_data <= '0;
      copy_end     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sram_read  <= (state_nxt == READ);
      sram_write <= pop;
      copy_end   <= pop & fifo_last[rd_ptr];
      if (dp_req) begin
        sram_addr <= dp_addr;
      end else if (pop) begin
        sram_addr    <= fifo_addr[rd_ptr];
        sram_wr_data <= fifo_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
      dp_hold <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(sram_read);
      if (dp_valid) dp_hold <= sram_rd_data;
    end
  end

  // Returned data is passed through in its valid cycle, held otherwise
  assign dp_valid = rd_pipe[RD_LAT-1];
  assign dp_data  = dp_valid ? sram_rd_data : dp_hold;

endmodule

// File: tb/tb_sram_vga_arbiter.sv
module tb_sram_vga_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cp_valid, cp_last, cp_ready, copy_window, copy_end;
  logic [ADDR_W-1:0] cp_addr, dp_addr, sram_addr;
  logic [DATA_W-1:0] cp_data, dp_data, sram_wr_data, sram_rd_data;
  logic              dp_req, dp_valid, sram_write, sram_read;
  logic [LVL_W-1:0]  fifo_level;

  always #5 clk = ~clk;

  sram_vga_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cp_valid(cp_valid), .cp_addr(cp_addr), .cp_data(cp_data), .cp_last(cp_last),
    .cp_ready(cp_ready), .copy_window(copy_window), .copy_end(copy_end),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_valid(dp_valid), .dp_data(dp_data),
    .sram_write(sram_write), .sram_read(sram_read), .sram_addr(sram_addr),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data), .fifo_level(fifo_level)
  );

  // SRAM read side: contents are a fixed function of address, data appears
  // RD_LAT cycles after the address was presented.
  function automatic logic [7:0] rom(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  logic [ADDR_W-1:0] ap [RD_LAT];
  always @(posedge clk) begin
    ap[0] <= sram_addr;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign sram_rd_data = rom(ap[RD_LAT-1]);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] due;
  } rd_t;

  // Reference model state
  wr_t  mfifo[$];
  wr_t  exp_wr[$];
  rd_t  exp_rd[$];
  int   lvl = 0;
  int   cyc = 0;
  bit   m_read = 0, m_write = 0, armed = 0;
  logic [7:0] m_raddr = '0;
  logic [7:0] last_dp = '0;

  int checks = 0;
  int fails  = 0;
  int n_wr = 0, n_ce = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: what the arbiter must put on the bus next cycle, from this cycle's inputs
  always @(posedge clk) begin
    bit  pop, acc;
    wr_t e;
    if (reset) begin
      lvl = 0;
      mfifo.delete();
      exp_wr.delete();
      exp_rd.delete();
      m_read  = 0;
      m_write = 0;
      last_dp = '0;
      armed   = 1;
    end else begin
      pop = !dp_req && (lvl > 0) && copy_window && !m_read;
      acc = cp_valid && (lvl != DEPTH);
      m_write = pop;
      if (pop) begin
        e = mfifo.pop_front();
        exp_wr.push_back(e);
      end
      if (acc) mfifo.push_back('{addr: cp_addr, data: cp_data, last: cp_last});
      lvl = lvl + int'(acc) - int'(pop);
      m_read = dp_req;
      if (dp_req) begin
        m_raddr = dp_addr;
        exp_rd.push_back('{data: rom(dp_addr), due: 32'(cyc + 1 + RD_LAT)});
      end
    end
    cyc++;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    wr_t e;
    rd_t r;
    if (armed) begin
      chk("sram_read", 32'(sram_read), 32'(m_read));
      if (m_read) chk("rd_addr", 32'(sram_addr), 32'(m_raddr));
      chk("sram_write", 32'(sram_write), 32'(m_write));
      chk("strobe_excl", 32'(sram_read & sram_write), 32'd0);
      chk("cp_ready", 32'(cp_ready), 32'(lvl != DEPTH));
      chk("fifo_level", 32'(fifo_level), 32'(lvl));
      if (sram_write) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(sram_write), 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(sram_addr), 32'(e.addr));
          chk("wr_data", 32'(sram_wr_data), 32'(e.data));
          chk("copy_end", 32'(copy_end), 32'(e.last));
        end
      end else begin
        chk("copy_end_idle", 32'(copy_end), 32'd0);
      end
      if (copy_end) n_ce++;
      if (dp_valid) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_dp_valid", 32'(dp_valid), 32'd0);
        end else begin
          r = exp_rd.pop_front();
          chk("dp_valid_time", 32'(cyc), r.due);
          chk("dp_data", 32'(dp_data), 32'(r.data));
          last_dp = r.data;
        end
      end else begin
        chk("dp_data_hold", 32'(dp_data), 32'(last_dp));
        if (exp_rd.size() != 0 && exp_rd[0].due <= 32'(cyc)) begin
          r = exp_rd.pop_front();
          chk("dp_valid_missing", 32'(dp_valid), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input logic l);
    bit r;
    int n;
    n = 0;
    cp_valid = 1'b1; cp_addr = a; cp_data = d; cp_last = l;
    do begin
      r = (lvl != DEPTH);
      tick();
      n++;
    end while (!r && n < 200);
    if (!r) chk("push_timeout", 32'd0, 32'd1);
    cp_valid = 1'b0;
  endtask

  initial begin
    int w0, c0;
    bit r;
    int n;
    cp_valid = 1'b1; cp_addr = 8'h55; cp_data = 8'h66; cp_last = 1'b1;
    copy_window = 1'b1; dp_req = 1'b0; dp_addr = '0;

    // 1: reset held two cycles with a word offered
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; cp_valid = 1'b0;
    @(negedge clk);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wr_data", 32'(sram_wr_data), 32'd0);
    chk("rst_dp_data", 32'(dp_data), 32'd0);
    chk("rst_dp_valid", 32'(dp_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_cp_ready", 32'(cp_ready), 32'd1);
    tick();

    // 2: write drain inside the copy window
    w0 = n_wr; c0 = n_ce;
    copy_window = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 8'(8'hA0 + i), i == 3);
    repeat (8) tick();
    chk("drain_writes", 32'(n_wr - w0), 32'd4);
    chk("drain_copy_end", 32'(n_ce - c0), 32'd1);

    // 3: full FIFO backpressure, then drain when the window opens
    w0 = n_wr;
    copy_window = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i), 8'(8'hB0 + i), 1'b0);
    cp_valid = 1'b1; cp_addr = 8'h34; cp_data = 8'hB4; cp_last = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("full_cp_ready", 32'(cp_ready), 32'd0);
    chk("full_no_writes", 32'(n_wr - w0), 32'd0);
    #4;
    copy_window = 1'b1;
    n = 0;
    do begin
      r = (lvl != DEPTH);
      tick();
      n++;
    end while (!r && n < 200);
    if (!r) chk("fifth_accept_timeout", 32'd0, 32'd1);
    cp_valid = 1'b0;
    repeat (10) tick();
    chk("full_writes", 32'(n_wr - w0), 32'd5);

    // 4: reads win over buffered writes; 5a: turnaround after reads
    copy_window = 1'b0;
    push(8'h40, 8'hC0, 1'b0);
    push(8'h41, 8'hC1, 1'b1);
    copy_window = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dp_req = 1'b1; dp_addr = 8'(8'h20 + i);
      tick();
    end
    dp_req = 1'b0;
    repeat (10) tick();

    // 5b: read requested while a write is on the bus
    copy_window = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h50 + i), 8'(8'hD0 + i), i == 2);
    copy_window = 1'b1;
    tick();
    tick();
    dp_req = 1'b1; dp_addr = 8'h77;
    tick();
    dp_req = 1'b0;
    repeat (10) tick();

    // 6: reset while a copy is buffered
    copy_window = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 8'(8'hE0 + i), i == 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    w0 = n_wr; c0 = n_ce;
    copy_window = 1'b1;
    repeat (8) tick();
    chk("midrst_writes", 32'(n_wr - w0), 32'd0);
    chk("midrst_copy_end", 32'(n_ce - c0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cp_valid    = 1'($urandom_range(0, 1));
      cp_addr     = 8'($urandom);
      cp_data     = 8'($urandom);
      cp_last     = ($urandom_range(0, 7) == 0);
      copy_window = ($urandom_range(0, 3) != 0);
      dp_req      = ($urandom_range(0, 3) == 0);
      dp_addr     = 8'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; cp_valid = 1'b0; dp_req = 1'b0; copy_window = 1'b1;
    repeat (20) tick();
    chk("final_level", 32'(fifo_level), 32'd0);
    chk("final_reads_pending", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
